// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and arbiter state encoding for the register-file
// writeback arbiter.
package regfile_wb_arbiter_pkg;

   localparam int REG_AW         = 5;
   localparam int DATA_W         = 32;
   localparam int NREGS          = 1 << REG_AW;
   localparam int STARVE_MAX_DEF = 4;

   typedef enum logic {
      ARB_NORMAL = 1'b0,
      ARB_FORCE  = 1'b1
   } arb_state_e;

endpackage

// File: rtl/wb_fifo2.sv
// Two-entry result queue for mul/div writebacks; entry 0 is always the head.
module wb_fifo2
   import regfile_wb_arbiter_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              push_i,
   input  logic [REG_AW-1:0] push_addr_i,
   input  logic [DATA_W-1:0] push_data_i,
   input  logic              pop_i,
   output logic              ready_o,
   output logic              empty_o,
   output logic [REG_AW-1:0] head_addr_o,
   output logic [DATA_W-1:0] head_data_o
);

   logic [1:0]        count_q, count_d;
   logic [REG_AW-1:0] a0_q, a0_d, a1_q, a1_d;
   logic [DATA_W-1:0] d0_q, d0_d, d1_q, d1_d;
   logic              push_ok, pop_ok;

   always_comb begin
      push_ok = push_i && (count_q != 2'd2);
      pop_ok  = pop_i && (count_q != 2'd0);
      a0_d    = a0_q;
      d0_d    = d0_q;
      a1_d    = a1_q;
      d1_d    = d1_q;
      if (pop_ok) begin
         a0_d = a1_q;
         d0_d = d1_q;
      end
      // With a simultaneous pop at count 1 the new entry lands directly in the head slot.
      if (push_ok) begin
         if ((count_q == 2'd0) || ((count_q == 2'd1) && pop_ok)) begin
            a0_d = push_addr_i;
            d0_d = push_data_i;
         end else begin
            a1_d = push_addr_i;
            d1_d = push_data_i;
         end
      end
      count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         a0_q    <= '0;
         d0_q    <= '0;
         a1_q    <= '0;
         d1_q    <= '0;
      end else begin
         count_q <= count_d;
         a0_q    <= a0_d;
         d0_q    <= d0_d;
         a1_q    <= a1_d;
         d1_q    <= d1_d;
      end
   end

   assign ready_o     = (count_q != 2'd2);
   assign empty_o     = (count_q == 2'd0);
   assign head_addr_o = a0_q;
   assign head_data_o = d0_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates pipeline writeback against queued mul/div results onto one
// registered register-file write port, with a busy-bit hazard scoreboard.
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int STARVE_MAX = STARVE_MAX_DEF
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_valid,
   input  logic [REG_AW-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              wb_stall,
   input  logic              md_valid,
   output logic              md_ready,
   input  logic [REG_AW-1:0] md_addr,
   input  logic [DATA_W-1:0] md_data,
   input  logic              iss_valid,
   input  logic [REG_AW-1:0] iss_addr,
   input  logic [REG_AW-1:0] q_rs,
   input  logic [REG_AW-1:0] q_rt,
   output logic              hz_stall,
   output logic              rf_wen,
   output logic [REG_AW-1:0] rf_wr,
   output logic [DATA_W-1:0] rf_wd
);

   localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

   arb_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [NREGS-1:0]  busy_q, busy_d;
   logic              rf_wen_q, rf_wen_d;
   logic [REG_AW-1:0] rf_wr_q, rf_wr_d;
   logic [DATA_W-1:0] rf_wd_q, rf_wd_d;
   logic              rf_src_md_q, rf_src_md_d;

   logic              fifo_ready, fifo_empty;
   logic [REG_AW-1:0] head_addr;
   logic [DATA_W-1:0] head_data;
   logic              grant_wb, grant_md, force_stall;

   wb_fifo2 u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (md_valid && fifo_ready),
      .push_addr_i (md_addr),
      .push_data_i (md_data),
      .pop_i       (grant_md),
      .ready_o     (fifo_ready),
      .empty_o     (fifo_empty),
      .head_addr_o (head_addr),
      .head_data_o (head_data)
   );

   always_comb begin
      grant_wb    = 1'b0;
      grant_md    = 1'b0;
      force_stall = 1'b0;
      state_d     = state_q;
      unique case (state_q)
         ARB_NORMAL: begin
            grant_wb = wb_valid;
            grant_md = !wb_valid && !fifo_empty;
         end
         ARB_FORCE: begin
            grant_md    = !fifo_empty;
            force_stall = wb_valid;
            state_d     = ARB_NORMAL;
         end
      endcase
      cnt_d = cnt_q;
      if (grant_md) begin
         cnt_d = '0;
      end else if (!fifo_empty) begin
         cnt_d = cnt_q + 1'b1;
      end
      // Forcing is decided on the count being loaded, so FORCE follows the last lost cycle directly.
      if ((state_q == ARB_NORMAL) && (cnt_d == CNT_W'(STARVE_MAX))) begin
         state_d = ARB_FORCE;
      end
   end

   always_comb begin
      rf_wen_d    = 1'b0;
      rf_wr_d     = rf_wr_q;
      rf_wd_d     = rf_wd_q;
      rf_src_md_d = 1'b0;
      if (grant_wb) begin
         rf_wen_d = (wb_addr != '0);
         rf_wr_d  = wb_addr;
         rf_wd_d  = wb_data;
      end else if (grant_md) begin
         rf_wen_d    = (head_addr != '0);
         rf_wr_d     = head_addr;
         rf_wd_d     = head_data;
         rf_src_md_d = 1'b1;
      end
   end

   always_comb begin
      busy_d = busy_q;
      if (rf_wen_q && rf_src_md_q) begin
         busy_d[rf_wr_q] = 1'b0;
      end
      if (iss_valid && (iss_addr != '0)) begin
         busy_d[iss_addr] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ARB_NORMAL;
         cnt_q       <= '0;
         busy_q      <= '0;
         rf_wen_q    <= 1'b0;
         rf_wr_q     <= '0;
         rf_wd_q     <= '0;
         rf_src_md_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         busy_q      <= busy_d;
         rf_wen_q    <= rf_wen_d;
         rf_wr_q     <= rf_wr_d;
         rf_wd_q     <= rf_wd_d;
         rf_src_md_q <= rf_src_md_d;
      end
   end

   assign wb_stall = force_stall && !rst;
   assign md_ready = fifo_ready;
   assign hz_stall = busy_q[q_rs] | busy_q[q_rt];
   assign rf_wen   = rf_wen_q;
   assign rf_wr    = rf_wr_q;
   assign rf_wd    = rf_wd_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected writes are queued as
// stimulus is driven and matched against the register-file port.
module tb_regfile_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_valid;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        wb_stall;
   logic        md_valid;
   logic        md_ready;
   logic [4:0]  md_addr;
   logic [31:0] md_data;
   logic        iss_valid;
   logic [4:0]  iss_addr;
   logic [4:0]  q_rs;
   logic [4:0]  q_rt;
   logic        hz_stall;
   logic        rf_wen;
   logic [4:0]  rf_wr;
   logic [31:0] rf_wd;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } wr_t;

   wr_t exp_q[$];

   always #5 clk = ~clk;

   regfile_wb_arbiter #(.STARVE_MAX(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .wb_valid  (wb_valid),
      .wb_addr   (wb_addr),
      .wb_data   (wb_data),
      .wb_stall  (wb_stall),
      .md_valid  (md_valid),
      .md_ready  (md_ready),
      .md_addr   (md_addr),
      .md_data   (md_data),
      .iss_valid (iss_valid),
      .iss_addr  (iss_addr),
      .q_rs      (q_rs),
      .q_rt      (q_rt),
      .hz_stall  (hz_stall),
      .rf_wen    (rf_wen),
      .rf_wr     (rf_wr),
      .rf_wd     (rf_wd)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
      wr_t e;
      e.a = a;
      e.d = d;
      exp_q.push_back(e);
   endtask

   // Every emitted write must match the oldest outstanding expectation.
   wr_t got;
   always @(negedge clk) begin
      if (rf_wen === 1'b1) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_write: observed addr=%0d data=0x%0h expected no write", rf_wr, rf_wd);
         end
         if (exp_q.size() != 0) begin
            got = exp_q.pop_front();
            chk("wr_addr", {27'b0, rf_wr}, {27'b0, got.a});
            chk("wr_data", rf_wd, got.d);
         end
      end
   end

   initial begin
      int k;
      int m;
      int p;
      logic force_c;
      logic rdy_c;

      rst = 1'b1;
      wb_valid = 1'b1;
      wb_addr = 5'd1;
      wb_data = 32'h0;
      md_valid = 1'b0;
      md_addr = '0;
      md_data = '0;
      iss_valid = 1'b0;
      iss_addr = '0;
      q_rs = '0;
      q_rt = '0;

      // Reset state
      step; step;
      chk("rst_rf_wen", {31'b0, rf_wen}, 0);
      chk("rst_rf_wr", {27'b0, rf_wr}, 0);
      chk("rst_rf_wd", rf_wd, 0);
      chk("rst_wb_stall", {31'b0, wb_stall}, 0);
      rst = 1'b0;
      wb_valid = 1'b0;
      #1;
      chk("rst_md_ready", {31'b0, md_ready}, 1);
      chk("rst_hz_stall", {31'b0, hz_stall}, 0);

      // Single pipeline writeback
      step;
      wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h1234;
      #1;
      chk("wb_single_stall", {31'b0, wb_stall}, 0);
      expect_wr(5'd3, 32'h1234);
      step;
      wb_valid = 1'b0;
      step; step;

      // Priority with starvation forcing
      md_valid = 1'b1; md_addr = 5'd5; md_data = 32'hAA;
      wb_valid = 1'b1; wb_addr = 5'd10; wb_data = 32'h100;
      #1;
      chk("prio_stall_c0", {31'b0, wb_stall}, 0);
      expect_wr(5'd10, 32'h100);
      step;
      md_valid = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         wb_data = 32'h100 + i;
         #1;
         chk("prio_stall_lost", {31'b0, wb_stall}, 0);
         expect_wr(5'd10, wb_data);
         step;
      end
      wb_data = 32'h105;
      #1;
      chk("prio_force_stall", {31'b0, wb_stall}, 1);
      expect_wr(5'd5, 32'hAA);
      step;
      #1;
      chk("prio_rf_wen", {31'b0, rf_wen}, 1);
      chk("prio_rf_wr", {27'b0, rf_wr}, 5);
      chk("prio_rf_wd", rf_wd, 32'hAA);
      chk("prio_stall_after", {31'b0, wb_stall}, 0);
      expect_wr(5'd10, 32'h105);
      step;
      wb_valid = 1'b0;
      step; step;

      // Scoreboard hazard
      q_rs = 5'd7; q_rt = 5'd0;
      iss_valid = 1'b1; iss_addr = 5'd7;
      #1;
      chk("hz_before_set", {31'b0, hz_stall}, 0);
      step;
      iss_valid = 1'b0;
      #1;
      chk("hz_set", {31'b0, hz_stall}, 1);
      step;
      md_valid = 1'b1; md_addr = 5'd7; md_data = 32'h77;
      expect_wr(5'd7, 32'h77);
      #1;
      chk("hz_pending", {31'b0, hz_stall}, 1);
      step;
      md_valid = 1'b0;
      #1;
      chk("hz_granted", {31'b0, hz_stall}, 1);
      step;
      #1;
      chk("hz_commit_wen", {31'b0, rf_wen}, 1);
      chk("hz_commit_wr", {27'b0, rf_wr}, 7);
      chk("hz_commit_stall", {31'b0, hz_stall}, 1);
      step;
      #1;
      chk("hz_cleared", {31'b0, hz_stall}, 0);
      q_rs = '0;
      step; step;

      // Full FIFO under continuous pipeline writeback
      k = 0; m = 0; p = 0;
      for (int c = 0; c <= 16; c++) begin
         force_c = (c == 5) || (c == 10) || (c == 15);
         rdy_c = (c <= 1) || (c == 6) || (c >= 11);
         wb_valid = 1'b1; wb_addr = 5'd12; wb_data = 32'h200 + k;
         md_valid = (m < 3); md_addr = 5'(20 + m); md_data = 32'h3000 + 20 + m;
         #1;
         chk("full_wb_stall", {31'b0, wb_stall}, {31'b0, force_c});
         chk("full_md_ready", {31'b0, md_ready}, {31'b0, rdy_c});
         if (force_c) begin
            expect_wr(5'(20 + p), 32'h3000 + 20 + p);
            p++;
         end else begin
            expect_wr(5'd12, 32'h200 + k);
            k++;
         end
         if (md_valid && rdy_c) m++;
         step;
      end
      wb_valid = 1'b0;
      md_valid = 1'b0;
      step; step;
      chk("full_drained", exp_q.size(), 0);

      // Zero-register writes are consumed silently
      md_valid = 1'b1; md_addr = 5'd0; md_data = 32'h55;
      wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'h66;
      iss_valid = 1'b1; iss_addr = 5'd0;
      step;
      md_valid = 1'b0; wb_valid = 1'b0; iss_valid = 1'b0;
      #1;
      chk("zero_hz", {31'b0, hz_stall}, 0);
      chk("zero_wen_c1", {31'b0, rf_wen}, 0);
      step;
      #1;
      chk("zero_wen_c2", {31'b0, rf_wen}, 0);
      md_valid = 1'b1; md_addr = 5'd4; md_data = 32'h44;
      expect_wr(5'd4, 32'h44);
      step;
      md_valid = 1'b0;
      step;
      #1;
      chk("zero_next_wen", {31'b0, rf_wen}, 1);
      chk("zero_next_wr", {27'b0, rf_wr}, 4);
      step; step;

      // Same-edge set and clear of r9
      q_rs = 5'd9;
      iss_valid = 1'b1; iss_addr = 5'd9;
      step;
      iss_valid = 1'b0;
      md_valid = 1'b1; md_addr = 5'd9; md_data = 32'h99;
      expect_wr(5'd9, 32'h99);
      step;
      md_valid = 1'b0;
      step;
      iss_valid = 1'b1; iss_addr = 5'd9;
      #1;
      chk("same_edge_wen", {31'b0, rf_wen}, 1);
      chk("same_edge_wr", {27'b0, rf_wr}, 9);
      step;
      iss_valid = 1'b0;
      #1;
      chk("same_edge_busy", {31'b0, hz_stall}, 1);
      step;
      #1;
      chk("same_edge_busy_hold", {31'b0, hz_stall}, 1);

      // Reset in the middle of queued work
      q_rs = 5'd3;
      iss_valid = 1'b1; iss_addr = 5'd3;
      wb_valid = 1'b1; wb_addr = 5'd13; wb_data = 32'h400;
      md_valid = 1'b1; md_addr = 5'd3; md_data = 32'h33;
      expect_wr(5'd13, 32'h400);
      step;
      iss_valid = 1'b0;
      wb_data = 32'h401;
      md_addr = 5'd8; md_data = 32'h88;
      #1;
      chk("mrst_ready_c1", {31'b0, md_ready}, 1);
      expect_wr(5'd13, 32'h401);
      step;
      md_valid = 1'b0;
      #1;
      chk("mrst_full", {31'b0, md_ready}, 0);
      chk("mrst_busy", {31'b0, hz_stall}, 1);
      rst = 1'b1;
      step;
      #1;
      chk("mrst_wen_in_rst", {31'b0, rf_wen}, 0);
      chk("mrst_stall_in_rst", {31'b0, wb_stall}, 0);
      step;
      rst = 1'b0;
      wb_valid = 1'b0;
      #1;
      chk("mrst_md_ready", {31'b0, md_ready}, 1);
      chk("mrst_hz_stall", {31'b0, hz_stall}, 0);
      for (int i = 0; i < 8; i++) begin
         step;
         chk("mrst_no_write", {31'b0, rf_wen}, 0);
      end
      chk("final_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
